// File: rtl/riscvssc_imem_merge.sv
// -----------------------------------------------------------------------------
// riscvssc_imem_merge
//
// Merges the dual-issue core's two instruction-fetch request ports onto one
// single-ported instruction memory and steers each response back to the port
// that issued it.
//
// Port 0 carries the older fetch slot and port 1 the younger one. When both
// ports are valid in the same cycle, a one-bit round-robin pointer picks the
// winner, so a pair presented together is issued 0 then 1. Every accepted
// request pushes its source port into a small in-order tag FIFO. The memory
// returns responses in request order, so the FIFO head always names the
// destination port of the current response.
//
// Ports
//   clk, reset               clock; synchronous active-low reset
//   imemreq{0,1}_msg/val/rdy core request ports (rdy = accepted this cycle)
//   imemresp{0,1}_msg/val    core response ports (no back-pressure)
//   memreq_msg/val/rdy       merged request to memory
//   memresp_msg/val          memory response (in request order)
//   outstanding              number of in-flight requests (FIFO occupancy)
//   err_unexp_resp           sticky: a response arrived with nothing in flight
// -----------------------------------------------------------------------------
module riscvssc_imem_merge #(
  parameter int REQ_SZ  = 67,
  parameter int RESP_SZ = 35,
  parameter int DEPTH   = 4,
  parameter int CW      = 3
) (
  input  logic               clk,
  input  logic               reset,

  input  logic [REQ_SZ-1:0]  imemreq0_msg,
  input  logic               imemreq0_val,
  output logic               imemreq0_rdy,

  input  logic [REQ_SZ-1:0]  imemreq1_msg,
  input  logic               imemreq1_val,
  output logic               imemreq1_rdy,

  output logic [RESP_SZ-1:0] imemresp0_msg,
  output logic               imemresp0_val,
  output logic [RESP_SZ-1:0] imemresp1_msg,
  output logic               imemresp1_val,

  output logic [REQ_SZ-1:0]  memreq_msg,
  output logic               memreq_val,
  input  logic               memreq_rdy,

  input  logic [RESP_SZ-1:0] memresp_msg,
  input  logic               memresp_val,

  output logic [CW-1:0]      outstanding,
  output logic               err_unexp_resp
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  // Tag FIFO: one bit per in-flight request, 0 = port 0, 1 = port 1.
  logic [DEPTH-1:0] tag_mem;
  ptr_t             head;
  ptr_t             tail;
  logic [CW-1:0]    count;
  logic             rr;
  logic             err;

  logic full;
  logic empty;
  logic gnt_any;
  logic gnt_idx;
  logic fire;
  logic pop;
  logic unexp;
  logic head_tag;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_tag = tag_mem[head];

  // Grant ignores memreq_rdy so the request is visible to memory even while
  // it stalls; only the full condition withholds it.
  // NOTE: every signal driven here gets a default first, so no path through
  // the if/else tree can leave it unassigned and infer a latch.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 1'b0;
    if (!full) begin
      if (imemreq0_val && imemreq1_val) begin
        gnt_any = 1'b1;
        gnt_idx = rr;
      end else if (imemreq0_val) begin
        gnt_any = 1'b1;
        gnt_idx = 1'b0;
      end else if (imemreq1_val) begin
        gnt_any = 1'b1;
        gnt_idx = 1'b1;
      end
    end
  end

  // All handshake outputs are gated by reset so nothing is offered or
  // accepted while reset is held, regardless of the register contents.
  assign memreq_val   = reset & gnt_any;
  assign memreq_msg   = gnt_idx ? imemreq1_msg : imemreq0_msg;
  assign fire         = memreq_val & memreq_rdy;
  assign imemreq0_rdy = fire & ~gnt_idx;
  assign imemreq1_rdy = fire &  gnt_idx;

  // Responses are steered combinationally from the FIFO head. A response
  // with nothing in flight is dropped and flagged.
  assign pop           = reset & memresp_val & ~empty;
  assign unexp         = memresp_val & empty;
  assign imemresp0_val = pop & ~head_tag;
  assign imemresp1_val = pop &  head_tag;
  assign imemresp0_msg = memresp_msg;
  assign imemresp1_msg = memresp_msg;

  assign outstanding    = count;
  assign err_unexp_resp = err;

  // NOTE: the tag storage has no reset. A location is only read after it has
  // been written by a push, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (fire) begin
      tag_mem[tail] <= gnt_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values and the update order within the block is
  // irrelevant.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rr    <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (fire) begin
        tail <= tail + ptr_t'(1);
      end
      if (pop) begin
        head <= head + ptr_t'(1);
      end

      // A push and a pop in the same cycle leave the occupancy unchanged.
      unique case ({fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Port 0 yields to a waiting port 1 after it wins. Port 1 always hands
      // priority back to port 0 after it wins.
      if (fire) begin
        if (gnt_idx) begin
          rr <= 1'b0;
        end else if (imemreq1_val) begin
          rr <= 1'b1;
        end
      end

      if (unexp) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_riscvssc_imem_merge.sv
// -----------------------------------------------------------------------------
// tb_riscvssc_imem_merge
//
// Stimulus is driven 1 time unit after each rising edge. At that point the
// reference model predicts the cycle's outputs and pushes them into
// scoreboard queues. A monitor on the falling edge pops the queues and
// compares them against the DUT.
//
// The reference model keeps the in-flight requests as a queue of source
// ports, plus a priority bit and an error flag.
// -----------------------------------------------------------------------------
module tb_riscvssc_imem_merge;

  localparam int REQ_SZ  = 67;
  localparam int RESP_SZ = 35;
  localparam int DEPTH   = 4;
  localparam int CW      = 3;

  logic               clk;
  logic               reset;
  logic [REQ_SZ-1:0]  imemreq0_msg;
  logic               imemreq0_val;
  logic               imemreq0_rdy;
  logic [REQ_SZ-1:0]  imemreq1_msg;
  logic               imemreq1_val;
  logic               imemreq1_rdy;
  logic [RESP_SZ-1:0] imemresp0_msg;
  logic               imemresp0_val;
  logic [RESP_SZ-1:0] imemresp1_msg;
  logic               imemresp1_val;
  logic [REQ_SZ-1:0]  memreq_msg;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [RESP_SZ-1:0] memresp_msg;
  logic               memresp_val;
  logic [CW-1:0]      outstanding;
  logic               err_unexp_resp;

  riscvssc_imem_merge #(
    .REQ_SZ (REQ_SZ),
    .RESP_SZ(RESP_SZ),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imemreq0_msg  (imemreq0_msg),
    .imemreq0_val  (imemreq0_val),
    .imemreq0_rdy  (imemreq0_rdy),
    .imemreq1_msg  (imemreq1_msg),
    .imemreq1_val  (imemreq1_val),
    .imemreq1_rdy  (imemreq1_rdy),
    .imemresp0_msg (imemresp0_msg),
    .imemresp0_val (imemresp0_val),
    .imemresp1_msg (imemresp1_msg),
    .imemresp1_val (imemresp1_val),
    .memreq_msg    (memreq_msg),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memresp_msg   (memresp_msg),
    .memresp_val   (memresp_val),
    .outstanding   (outstanding),
    .err_unexp_resp(err_unexp_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs.
  typedef struct {
    bit               rdy0;
    bit               rdy1;
    bit               mval;
    logic [REQ_SZ-1:0] mmsg;
    int               outst;
    bit               err;
    bit               rv0;
    bit               rv1;
  } cyc_t;

  // Expected transaction (issued request or steered response).
  typedef struct {
    bit           port;
    logic [127:0] msg;
  } txn_t;

  cyc_t cyc_q[$];
  txn_t req_q[$];
  txn_t resp_q[$];

  // Reference model state.
  bit m_tags[$];
  bit m_rr;
  bit m_err;

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [REQ_SZ-1:0] mk_req(input logic [31:0] addr);
    return {1'b0, addr, 2'b00, 32'h0};
  endfunction

  function automatic logic [RESP_SZ-1:0] mk_resp(input logic [31:0] data);
    return {1'b0, 2'b00, data};
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic drive_cycle(input bit rst, input bit v0, input logic [REQ_SZ-1:0] m0,
                             input bit v1, input logic [REQ_SZ-1:0] m1, input bit mrdy,
                             input bit rv, input logic [RESP_SZ-1:0] rmsg);
    cyc_t c;
    txn_t t;
    bit   full;
    bit   have;
    bit   pick;
    bit   fire;
    bit   p;
    @(posedge clk);
    #1;
    reset        = rst;
    imemreq0_val = v0;
    imemreq0_msg = m0;
    imemreq1_val = v1;
    imemreq1_msg = m1;
    memreq_rdy   = mrdy;
    memresp_val  = rv;
    memresp_msg  = rmsg;

    c.rdy0  = 1'b0;
    c.rdy1  = 1'b0;
    c.mval  = 1'b0;
    c.mmsg  = '0;
    c.rv0   = 1'b0;
    c.rv1   = 1'b0;
    c.outst = m_tags.size();
    c.err   = m_err;

    if (!rst) begin
      m_tags.delete();
      m_rr  = 1'b0;
      m_err = 1'b0;
    end else begin
      full = (m_tags.size() == DEPTH);
      have = !full && (v0 || v1);
      pick = (v0 && v1) ? m_rr : v1;
      fire = have && mrdy;
      c.mval = have;
      c.mmsg = pick ? m1 : m0;
      c.rdy0 = fire && !pick;
      c.rdy1 = fire && pick;
      if (rv) begin
        if (m_tags.size() > 0) begin
          p      = m_tags.pop_front();
          c.rv0  = !p;
          c.rv1  = p;
          t.port = p;
          t.msg  = 128'(rmsg);
          resp_q.push_back(t);
        end else begin
          m_err = 1'b1;
        end
      end
      if (fire) begin
        m_tags.push_back(pick);
        t.port = pick;
        t.msg  = 128'(pick ? m1 : m0);
        req_q.push_back(t);
        if (pick) m_rr = 1'b0;
        else if (v1) m_rr = 1'b1;
      end
    end
    cyc_q.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, '0, 0, '0, 1, 0, '0);
  endtask

  task automatic respond(input logic [31:0] data);
    drive_cycle(1, 0, '0, 0, '0, 1, 1, mk_resp(data));
  endtask

  // Monitor: compare on the falling edge, away from the sampling edge.
  cyc_t mon_c;
  txn_t mon_t;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_c = cyc_q.pop_front();
      check("imemreq0_rdy",   128'(imemreq0_rdy),   128'(mon_c.rdy0));
      check("imemreq1_rdy",   128'(imemreq1_rdy),   128'(mon_c.rdy1));
      check("memreq_val",     128'(memreq_val),     128'(mon_c.mval));
      if (mon_c.mval) check("memreq_msg", 128'(memreq_msg), 128'(mon_c.mmsg));
      check("outstanding",    128'(outstanding),    128'(mon_c.outst));
      check("err_unexp_resp", 128'(err_unexp_resp), 128'(mon_c.err));
      check("imemresp0_val",  128'(imemresp0_val),  128'(mon_c.rv0));
      check("imemresp1_val",  128'(imemresp1_val),  128'(mon_c.rv1));
    end
    if (memreq_val === 1'b1 && memreq_rdy === 1'b1) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 128'(1), 128'(0));
      end else begin
        mon_t = req_q.pop_front();
        check("req_port", 128'(imemreq1_rdy), 128'(mon_t.port));
        check("req_msg",  128'(memreq_msg),   mon_t.msg);
      end
    end
    if (imemresp0_val === 1'b1 || imemresp1_val === 1'b1) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 128'(1), 128'(0));
      end else begin
        mon_t = resp_q.pop_front();
        check("resp_port", 128'(imemresp1_val), 128'(mon_t.port));
        check("resp_data", mon_t.port ? 128'(imemresp1_msg) : 128'(imemresp0_msg), mon_t.msg);
      end
    end
  end

  logic [95:0]        rnd0;
  logic [95:0]        rnd1;
  logic [RESP_SZ-1:0] rmsg;
  bit                 rst_r;
  bit                 rv_r;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    imemreq0_val = 1'b1;
    imemreq1_val = 1'b1;
    imemreq0_msg = '0;
    imemreq1_msg = '0;
    memreq_rdy   = 1'b1;
    memresp_val  = 1'b0;
    memresp_msg  = '0;
    m_rr         = 1'b0;
    m_err        = 1'b0;

    // Reset held with both ports valid and memory ready.
    drive_cycle(0, 1, mk_req(32'h1000), 1, mk_req(32'h1004), 1, 0, '0);
    drive_cycle(0, 1, mk_req(32'h1000), 1, mk_req(32'h1004), 1, 0, '0);
    idle(1);

    // Pair presented together: port 0 first, then port 1.
    drive_cycle(1, 1, mk_req(32'h1000), 1, mk_req(32'h1004), 1, 0, '0);
    drive_cycle(1, 1, mk_req(32'h1008), 1, mk_req(32'h1004), 1, 0, '0);
    idle(1);
    respond(32'hAAAA);
    respond(32'hBBBB);
    idle(1);

    // Fill from port 1, stall on full, pop does not refill the same cycle.
    for (int i = 0; i < 6; i++)
      drive_cycle(1, 0, '0, 1, mk_req(32'h2000 + 32'(4 * i)), 1, 0, '0);
    drive_cycle(1, 0, '0, 1, mk_req(32'h2100), 1, 1, mk_resp(32'hC000));
    drive_cycle(1, 0, '0, 1, mk_req(32'h2100), 1, 0, '0);
    for (int i = 0; i < 4; i++) respond(32'hD000 + 32'(i));

    // Memory stalls with port 0 valid.
    for (int i = 0; i < 3; i++) drive_cycle(1, 1, mk_req(32'h3000), 0, '0, 0, 0, '0);
    drive_cycle(1, 1, mk_req(32'h3000), 0, '0, 1, 0, '0);
    respond(32'hE000);

    // Unexpected response sets the sticky flag until reset.
    respond(32'hF000);
    idle(3);
    drive_cycle(0, 0, '0, 0, '0, 1, 0, '0);
    idle(1);

    // Reset discards in-flight tags; a later response is unexpected.
    drive_cycle(1, 1, mk_req(32'h4000), 1, mk_req(32'h4004), 1, 0, '0);
    drive_cycle(1, 0, '0, 1, mk_req(32'h4004), 1, 0, '0);
    drive_cycle(0, 0, '0, 0, '0, 1, 0, '0);
    respond(32'h1234);
    idle(2);
    drive_cycle(0, 0, '0, 0, '0, 1, 0, '0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rnd0  = {$urandom, $urandom, $urandom};
      rnd1  = {$urandom, $urandom, $urandom};
      rmsg  = rnd0[95:96-RESP_SZ];
      rst_r = ($urandom_range(199) != 0);
      rv_r  = (m_tags.size() > 0) ? ($urandom_range(2) != 0) : ($urandom_range(49) == 0);
      drive_cycle(rst_r, $urandom_range(3) != 0, rnd0[REQ_SZ-1:0],
                  $urandom_range(3) != 0, rnd1[REQ_SZ-1:0],
                  $urandom_range(3) != 0, rv_r, rmsg);
    end
    idle(2);
    @(negedge clk);
    #1;

    check("cyc_q_drained",  128'(cyc_q.size()),  128'(0));
    check("req_q_drained",  128'(req_q.size()),  128'(0));
    check("resp_q_drained", 128'(resp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
